// File: rtl/decimal_converter_seq_pkg.sv
// decimal_converter_seq_pkg: shared FSM state type, BCD digit width and clog2 helper.
// Revision 1.0
`default_nettype none

package decimal_converter_seq_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decimal_converter_seq_if.sv
// decimal_converter_seq_if: input/output valid-ready streams of the binary-to-BCD converter.
// Revision 1.0
`default_nettype none

interface decimal_converter_seq_if
  import decimal_converter_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int NDIG_W = clog2(DIGITS + 1)
);

  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [BCD_W*DIGITS-1:0]   out_bcd;
  logic [NDIG_W-1:0]         out_ndigits;
  logic                      out_overflow;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bcd, out_ndigits, out_overflow
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bcd, out_ndigits, out_overflow
  );

endinterface

`default_nettype wire

// File: rtl/decimal_converter_seq_digit_adjust.sv
// bcd_digit_adjust: one double-dabble correction (add 3 to digits of 5 and above).
// Revision 1.0
`default_nettype none

module bcd_digit_adjust
  import decimal_converter_seq_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  assign dout = (din >= BCD_W'(5)) ? din + BCD_W'(3) : din;

endmodule

`default_nettype wire

// File: rtl/decimal_converter_seq.sv
// decimal_converter_seq: iterative shift-add-3 binary to packed BCD converter, one bit per cycle.
// Revision 1.0
`default_nettype none

module decimal_converter_seq
  import decimal_converter_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  decimal_converter_seq_if.slave bus
);

  localparam int NDIG_W = clog2(DIGITS + 1);
  localparam int ACC_W  = BCD_W * DIGITS;
  localparam int CNT_W  = clog2(WIDTH + 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_shift;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;
  logic [ACC_W-1:0]   r_bcd;
  logic [NDIG_W-1:0]  r_ndigits;
  logic               r_overflow;

  logic [ACC_W-1:0]   w_adj;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_carry;
  logic               w_last;
  logic               w_accept;
  logic [NDIG_W-1:0]  w_ndigits;

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_adjust u_adj (
        .din  (r_acc[g*BCD_W +: BCD_W]),
        .dout (w_adj[g*BCD_W +: BCD_W])
      );
    end
  endgenerate

  // The bit leaving the top digit is the lost 10^DIGITS carry.
  assign w_carry    = w_adj[ACC_W-1];
  assign w_acc_next = {w_adj[ACC_W-2:0], r_shift[WIDTH-1]};
  assign w_last     = (r_count == CNT_W'(1));
  assign w_accept   = (r_state == ST_IDLE) && bus.in_valid;

  always_comb begin
    w_ndigits = NDIG_W'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (w_acc_next[i*BCD_W +: BCD_W] != '0) begin
        w_ndigits = NDIG_W'(i + 1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.in_valid)  w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_last)        w_state_next = ST_DONE;
      ST_DONE:  if (bus.out_ready) w_state_next = ST_IDLE;
      default:                     w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_acc      <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_bcd      <= '0;
      r_ndigits  <= NDIG_W'(1);
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_shift <= bus.in_data;
        r_acc   <= '0;
        r_count <= CNT_W'(WIDTH);
        r_ovf   <= 1'b0;
      end else if (r_state == ST_SHIFT) begin
        r_shift <= r_shift << 1;
        r_acc   <= w_acc_next;
        r_count <= r_count - CNT_W'(1);
        r_ovf   <= r_ovf | w_carry;
        if (w_last) begin
          r_bcd      <= w_acc_next;
          r_ndigits  <= w_ndigits;
          r_overflow <= r_ovf | w_carry;
        end
      end
    end
  end

  assign bus.in_ready     = (r_state == ST_IDLE);
  assign bus.out_valid    = (r_state == ST_DONE);
  assign bus.out_bcd      = r_bcd;
  assign bus.out_ndigits  = r_ndigits;
  assign bus.out_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_decimal_converter_seq.sv
// tb_decimal_converter_seq: directed checks of three converter configurations (8/3, 8/2, 16/5).
// Revision 1.0
`default_nettype none

module tb_decimal_converter_seq;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  decimal_converter_seq_if #(.WIDTH(8),  .DIGITS(3)) b0 ();
  decimal_converter_seq_if #(.WIDTH(8),  .DIGITS(2)) b1 ();
  decimal_converter_seq_if #(.WIDTH(16), .DIGITS(5)) b2 ();

  decimal_converter_seq #(.WIDTH(8),  .DIGITS(3)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  decimal_converter_seq #(.WIDTH(8),  .DIGITS(2)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  decimal_converter_seq #(.WIDTH(16), .DIGITS(5)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));

  function automatic logic [11:0] bcd3(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [1:0] nd3(input int v);
    return (v >= 100) ? 2'd3 : (v >= 10) ? 2'd2 : 2'd1;
  endfunction

  // Runs one conversion on instance sel; returns result fields and edges from accept to out_valid.
  task automatic conv(input int sel, input logic [15:0] v, output logic [19:0] bcd,
                      output logic [2:0] nd, output logic ovf, output int lat);
    logic vld;
    @(negedge clk);
    case (sel)
      0:       begin b0.in_data = v[7:0]; b0.in_valid = 1'b1; end
      1:       begin b1.in_data = v[7:0]; b1.in_valid = 1'b1; end
      default: begin b2.in_data = v;      b2.in_valid = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    b0.in_valid = 1'b0; b1.in_valid = 1'b0; b2.in_valid = 1'b0;
    b0.in_data = '1; b1.in_data = '1; b2.in_data = '1;
    lat = 0;
    vld = 1'b0;
    while (!vld && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      case (sel)
        0:       vld = b0.out_valid;
        1:       vld = b1.out_valid;
        default: vld = b2.out_valid;
      endcase
    end
    case (sel)
      0:       begin bcd = 20'(b0.out_bcd); nd = 3'(b0.out_ndigits); ovf = b0.out_overflow; b0.out_ready = 1'b1; end
      1:       begin bcd = 20'(b1.out_bcd); nd = 3'(b1.out_ndigits); ovf = b1.out_overflow; b1.out_ready = 1'b1; end
      default: begin bcd = b2.out_bcd;      nd = b2.out_ndigits;     ovf = b2.out_overflow; b2.out_ready = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    b0.out_ready = 1'b0; b1.out_ready = 1'b0; b2.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", b0.out_valid); end
    n_cmp++; if (b0.out_bcd !== 12'h000) begin n_fail++; $display("FAIL reset_bcd: got %0h want 000", b0.out_bcd); end
    n_cmp++; if (b0.out_ndigits !== 2'd1) begin n_fail++; $display("FAIL reset_nd: got %0d want 1", b0.out_ndigits); end
    n_cmp++; if (b0.out_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b want 0", b0.out_overflow); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", b0.in_ready); end
  endtask

  task automatic test_basic;
    logic [15:0] vals [4] = '{16'd0, 16'd255, 16'd100, 16'd9};
    logic [11:0] eb   [4] = '{12'h000, 12'h255, 12'h100, 12'h009};
    logic [2:0]  en   [4] = '{3'd1, 3'd3, 3'd3, 3'd1};
    logic [19:0] bcd; logic [2:0] nd; logic ovf; int lat;
    for (int i = 0; i < 4; i++) begin
      conv(0, vals[i], bcd, nd, ovf, lat);
      n_cmp++; if (bcd !== 20'(eb[i])) begin n_fail++; $display("FAIL basic_bcd(%0d): got %0h want %0h", vals[i], bcd, eb[i]); end
      n_cmp++; if (nd !== en[i]) begin n_fail++; $display("FAIL basic_nd(%0d): got %0d want %0d", vals[i], nd, en[i]); end
      n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf(%0d): got %0b want 0", vals[i], ovf); end
      n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL basic_latency(%0d): got %0d want 8", vals[i], lat); end
    end
  endtask

  task automatic test_sweep;
    int nxt = 0, got = 0, cyc = 0, last = 0;
    b0.out_ready = 1'b1;
    b0.in_valid  = 1'b0;
    while (got < 256 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (b0.out_valid) begin
        n_cmp++;
        if (b0.out_bcd !== bcd3(got) || b0.out_ndigits !== nd3(got) || b0.out_overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep(%0d): got %0h/%0d/%0b want %0h/%0d/0", got, b0.out_bcd,
                   b0.out_ndigits, b0.out_overflow, bcd3(got), nd3(got));
        end
        if (got > 0) begin
          n_cmp++; if (cyc - last !== 10) begin n_fail++; $display("FAIL sweep_period(%0d): got %0d want 10", got, cyc - last); end
        end
        last = cyc;
        got++;
      end
      if (b0.in_ready) begin
        b0.in_valid = (nxt < 256);
        b0.in_data  = 8'(nxt);
        if (nxt < 256) nxt++;
      end
    end
    n_cmp++; if (got !== 256) begin n_fail++; $display("FAIL sweep_count: got %0d want 256", got); end
    @(negedge clk);
    b0.in_valid = 1'b0; b0.out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int lat = 0;
    int bad = 0;
    @(negedge clk);
    b0.in_data = 8'd123; b0.in_valid = 1'b1;
    @(posedge clk); #1; b0.in_valid = 1'b0;
    while (!b0.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b0.out_valid !== 1'b1 || b0.in_ready !== 1'b0 || b0.out_bcd !== 12'h123 ||
          b0.out_ndigits !== 2'd3 || b0.out_overflow !== 1'b0) bad++;
      b0.in_valid = (i == 5);
      b0.in_data  = 8'd7;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
    b0.in_valid = 1'b0; b0.out_ready = 1'b1;
    @(posedge clk); #1; b0.out_ready = 1'b0;
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %0b want 0", b0.out_valid); end
    n_cmp++; if (b0.out_bcd !== 12'h123) begin n_fail++; $display("FAIL bp_hold: got %0h want 123", b0.out_bcd); end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL bp_no_queue: got %0d busy cycles want 0", bad); end
  endtask

  task automatic test_async_reset;
    logic [19:0] bcd; logic [2:0] nd; logic ovf; int lat;
    @(negedge clk);
    b0.in_data = 8'd200; b0.in_valid = 1'b1;
    @(posedge clk); #1; b0.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (b0.out_bcd !== 12'h000) begin n_fail++; $display("FAIL arst_bcd: got %0h want 000", b0.out_bcd); end
    n_cmp++; if (b0.out_ndigits !== 2'd1) begin n_fail++; $display("FAIL arst_nd: got %0d want 1", b0.out_ndigits); end
    n_cmp++; if (b0.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b want 0", b0.out_valid); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (b0.in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %0b want 1", b0.in_ready); end
    conv(0, 16'd42, bcd, nd, ovf, lat);
    n_cmp++; if (bcd !== 20'h00042) begin n_fail++; $display("FAIL arst_42_bcd: got %0h want 042", bcd); end
    n_cmp++; if (nd !== 3'd2) begin n_fail++; $display("FAIL arst_42_nd: got %0d want 2", nd); end
  endtask

  task automatic test_overflow;
    logic [19:0] bcd; logic [2:0] nd; logic ovf; int lat;
    conv(1, 16'd200, bcd, nd, ovf, lat);
    n_cmp++; if (bcd !== 20'h00) begin n_fail++; $display("FAIL ovf200_bcd: got %0h want 00", bcd); end
    n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf200_flag: got %0b want 1", ovf); end
    n_cmp++; if (nd !== 3'd1) begin n_fail++; $display("FAIL ovf200_nd: got %0d want 1", nd); end
    conv(1, 16'd99, bcd, nd, ovf, lat);
    n_cmp++; if (bcd !== 20'h99) begin n_fail++; $display("FAIL d2_99_bcd: got %0h want 99", bcd); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL d2_99_flag: got %0b want 0", ovf); end
    conv(1, 16'd150, bcd, nd, ovf, lat);
    n_cmp++; if (bcd !== 20'h50 || ovf !== 1'b1) begin n_fail++; $display("FAIL ovf150: got %0h/%0b want 50/1", bcd, ovf); end
    conv(2, 16'd65535, bcd, nd, ovf, lat);
    n_cmp++; if (bcd !== 20'h65535) begin n_fail++; $display("FAIL w16_bcd: got %0h want 65535", bcd); end
    n_cmp++; if (nd !== 3'd5) begin n_fail++; $display("FAIL w16_nd: got %0d want 5", nd); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL w16_ovf: got %0b want 0", ovf); end
    n_cmp++; if (lat !== 16) begin n_fail++; $display("FAIL w16_latency: got %0d want 16", lat); end
    conv(2, 16'd1000, bcd, nd, ovf, lat);
    n_cmp++; if (bcd !== 20'h01000 || nd !== 3'd4) begin n_fail++; $display("FAIL w16_1000: got %0h/%0d want 01000/4", bcd, nd); end
  endtask

  initial begin
    reset = 1'b1;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_sweep();
    test_backpressure();
    test_async_reset();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
